// File: rtl/posit_add.sv
`default_nettype none
// ============================================================================
//  Module      : posit_add
//  Description : Registered posit adder, out = in1 + in2, rounded to nearest
//                with ties to even. Combinational decode / align / add /
//                normalize / encode followed by one output register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_add #(
  parameter int N  = 32,
  parameter int es = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int Bs  = $clog2(N);       // width of regime / shift counts
  localparam int NM1 = N - 1;
  localparam int SW  = es + Bs + 4;     // signed scale width with headroom
  localparam int DW  = 2 * N;           // aligned mantissa field width
  localparam int FW  = DW + 1;          // aligned field plus carry
  localparam int TW  = 4 * N;           // encode string width

  localparam logic [N-1:0]         c_nar    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]         c_maxpos = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]         c_minpos = {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] c_dmax   = SW'(DW);
  localparam logic signed [SW-1:0] c_kmax   = SW'(N - 2);
  localparam logic signed [SW-1:0] c_kmin   = SW'(2 - N);
  localparam logic [SW-1:0]        c_emask  = SW'((1 << es) - 1);

  // Number of leading zeros in v (N-1 when v is all zeros).
  function automatic logic [Bs-1:0] lzc(input logic [NM1-1:0] v);
    logic [Bs-1:0] cnt;
    logic          found;
    cnt   = '0;
    found = 1'b0;
    for (int i = NM1 - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      cnt = cnt + 1'b1;
      end
    end
    return cnt;
  endfunction

  // Bit index of the most significant one (0 when v is zero).
  function automatic int lead_pos(input logic [FW-1:0] v);
    int p;
    p = 0;
    for (int i = 0; i < FW; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  // Split a posit into sign, signed scale and mantissa with hidden one at MSB.
  function automatic void decode(input  logic [N-1:0]         x,
                                 output logic                 sgn,
                                 output logic signed [SW-1:0] scl,
                                 output logic [N-1:0]         mnt);
    logic [NM1-1:0]       body;
    logic [NM1-1:0]       rem;
    logic [NM1-1:0]       frac;
    logic [Bs-1:0]        run;
    logic signed [SW-1:0] k;
    logic signed [SW-1:0] ex;
    sgn  = x[N-1];
    body = NM1'(sgn ? (~x + 1'b1) : x);
    run  = lzc(body[NM1-1] ? ~body : body);
    // drop the regime run and its terminating bit; absent bits read as zero
    rem  = body << (int'(run) + 1);
    ex   = SW'(rem >> (NM1 - es));
    frac = rem << es;
    mnt  = {1'b1, frac};
    k    = body[NM1-1] ? (SW'(run) - SW'(1)) : (SW'(0) - SW'(run));
    scl  = (k <<< es) + ex;
  endfunction

  logic                 w_sa, w_sb;
  logic signed [SW-1:0] w_ea, w_eb;
  logic [N-1:0]         w_ma, w_mb;

  // Operand decode.
  always_comb begin
    decode(in1, w_sa, w_ea, w_ma);
    decode(in2, w_sb, w_eb, w_mb);
  end

  logic                 w_a_big, w_bsgn, w_same;
  logic signed [SW-1:0] w_ebig, w_diff, w_e, w_k;
  logic [N-1:0]         w_mbig, w_msml;
  int                   w_sh, w_p, w_kk, w_rlen;
  logic [TW-1:0]        w_wide, w_rbits, w_ef, w_t;
  logic [DW-1:0]        w_sal, w_frac;
  logic [FW-1:0]        w_big_al, w_sml_al, w_sum;
  logic [SW-1:0]        w_expo;
  logic                 w_stk, w_guard, w_stk2, w_rnd;
  logic [N-1:0]         w_mag, w_smag, w_out;
  logic                 w_inf, w_zero;

  // Align, add/subtract, normalize, encode with rounding and saturation.
  always_comb begin
    w_a_big = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
    w_bsgn  = w_a_big ? w_sa : w_sb;
    w_same  = (w_sa == w_sb);
    w_ebig  = w_a_big ? w_ea : w_eb;
    w_mbig  = w_a_big ? w_ma : w_mb;
    w_msml  = w_a_big ? w_mb : w_ma;
    w_diff  = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    w_sh    = (w_diff > c_dmax) ? DW : int'(w_diff);

    // small mantissa goes into the upper half; the lower half catches sticky bits
    w_wide   = {w_msml, {(TW-N){1'b0}}} >> w_sh;
    w_sal    = w_wide[TW-1 -: DW];
    w_stk    = |w_wide[DW-1:0];
    w_big_al = {1'b0, w_mbig, {N{1'b0}}};
    w_sml_al = {1'b0, w_sal[DW-1:1], w_sal[0] | w_stk};
    w_sum    = w_same ? (w_big_al + w_sml_al) : (w_big_al - w_sml_al);

    // leading one moves to bit DW and is dropped; scale follows its position
    w_p    = lead_pos(w_sum);
    w_frac = DW'(w_sum << (DW - w_p));
    w_e    = w_ebig + SW'(w_p) - SW'(DW - 1);
    w_k    = w_e >>> es;
    w_expo = w_e & c_emask;
    w_kk   = int'(w_k);

    if (w_kk >= 0) begin
      w_rbits = ~({TW{1'b1}} >> (w_kk + 1));
      w_rlen  = w_kk + 2;
    end else begin
      w_rbits = {1'b1, {(TW-1){1'b0}}} >> (-w_kk);
      w_rlen  = 1 - w_kk;
    end
    w_ef = (TW'(w_expo) << DW) | TW'(w_frac);
    w_t  = w_rbits | ((w_ef << (DW - es)) >> w_rlen);

    w_guard = w_t[TW-N];
    w_stk2  = |w_t[TW-N-1:0];
    w_rnd   = w_guard & (w_t[TW-N+1] | w_stk2);
    w_mag   = {1'b0, w_t[TW-1 -: NM1]} + N'(w_rnd);

    if (w_k >= c_kmax)     w_smag = c_maxpos;
    else if (w_k < c_kmin) w_smag = c_minpos;
    else                   w_smag = w_mag;
    w_out = w_bsgn ? (~w_smag + 1'b1) : w_smag;

    // special operands override the arithmetic path, NaR last so it wins
    if (w_sum == '0) w_out = '0;
    if (in1 == '0)      w_out = in2;
    else if (in2 == '0) w_out = in1;
    if ((in1 == c_nar) || (in2 == c_nar)) w_out = c_nar;

    w_inf  = (w_out == c_nar);
    w_zero = (w_out == '0);
  end

  // Output register: capture on start, done pulses the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      inf  <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        out  <= w_out;
        inf  <= w_inf;
        zero <= w_zero;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_add
//  Description : Self-checking bench for posit_add (N=32, es=2). Directed
//                cases plus random operands compared with an exact-value
//                reference that rounds by searching the posit code line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_add;

  localparam int N   = 32;
  localparam int ES  = 2;
  localparam int OFF = 160;   // fixed-point offset: value = X / 2^OFF
  localparam logic [N-1:0] NAR  = 32'h8000_0000;
  localparam logic [N-1:0] MAXP = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINP = 32'h0000_0001;

  typedef logic [319:0] wide_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] in1, in2, out;
  logic         inf, zero, done;
  int           checks = 0;
  int           errors = 0;

  posit_add #(.N(N), .es(ES)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .start(start),
    .out(out), .inf(inf), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  // Exact value of a positive nb-bit posit code, scaled by 2^OFF.
  function automatic wide_t pval(input logic [63:0] code, input int nb);
    int    i, run, k, e, fb, scale;
    logic  first;
    wide_t sig;
    i     = nb - 2;
    first = code[i];
    run   = 0;
    while (i >= 0) begin
      if (code[i] != first) break;
      run++;
      i--;
    end
    k = first ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = 2 * e;
      if (i >= 0) begin
        e = e + int'(code[i]);
        i--;
      end
    end
    sig = wide_t'(1);
    fb  = 0;
    while (i >= 0) begin
      sig = (sig << 1) | wide_t'(code[i]);
      fb++;
      i--;
    end
    scale = k * (1 << ES) + e;
    return sig << (OFF + scale - fb);
  endfunction

  // Nearest posit (ties to even on the bit string) to a positive exact value.
  function automatic logic [N-1:0] round_pos(input wide_t x);
    logic [N-1:0] lo, hi, md;
    logic [63:0]  ext;
    wide_t        vm;
    if (x >= pval(64'(MAXP), N)) return MAXP;
    if (x <= pval(64'(MINP), N)) return MINP;
    lo = MINP;
    hi = MAXP;
    while (hi != lo + MINP) begin
      md = lo + ((hi - lo) >> 1);
      if (pval(64'(md), N) <= x) lo = md;
      else                       hi = md;
    end
    if (pval(64'(lo), N) == x) return lo;
    ext = (64'(lo) << 1) | 64'd1;
    vm  = pval(ext, N + 1);
    if (x > vm) return lo + MINP;
    if (x < vm) return lo;
    return lo[0] ? lo + MINP : lo;
  endfunction

  function automatic logic [N-1:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
    wide_t        xa, xb, xs;
    logic         s;
    logic [N-1:0] ma, mb, r;
    if (a == NAR || b == NAR) return NAR;
    if (a == '0) return b;
    if (b == '0) return a;
    ma = a[N-1] ? (~a + 1'b1) : a;
    mb = b[N-1] ? (~b + 1'b1) : b;
    xa = pval(64'(ma), N);
    xb = pval(64'(mb), N);
    if (a[N-1] == b[N-1]) begin
      xs = xa + xb;
      s  = a[N-1];
    end else if (xa == xb) begin
      return '0;
    end else if (xa > xb) begin
      xs = xa - xb;
      s  = a[N-1];
    end else begin
      xs = xb - xa;
      s  = b[N-1];
    end
    r = round_pos(xs);
    return s ? (~r + 1'b1) : r;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = $urandom;
      1:       v = 32'h3000_0000 + ($urandom & 32'h1FFF_FFFF);
      2:       v = $urandom & 32'h0000_FFFF;
      3:       v = MAXP - ($urandom & 32'h0000_FFFF);
      4:       v = 32'h4000_0000 + ($urandom & 32'h000F_FFFF);
      default: begin
        case ($urandom_range(0, 3))
          0:       v = '0;
          1:       v = NAR;
          2:       v = MINP;
          default: v = MAXP;
        endcase
      end
    endcase
    if ($urandom_range(0, 1) == 1) v = ~v + 1'b1;
    return v;
  endfunction

  // One clock: drive on the falling edge, let the rising edge capture.
  task automatic cyc(input logic r, input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    rst   = r;
    start = s;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] eo, input logic ei,
                     input logic ez, input logic ed);
    checks++;
    assert (out === eo) else begin
      errors++;
      $error("FAIL %s out: observed=%h expected=%h", tag, out, eo);
    end
    checks++;
    assert (inf === ei) else begin
      errors++;
      $error("FAIL %s inf: observed=%b expected=%b", tag, inf, ei);
    end
    checks++;
    assert (zero === ez) else begin
      errors++;
      $error("FAIL %s zero: observed=%b expected=%b", tag, zero, ez);
    end
    checks++;
    assert (done === ed) else begin
      errors++;
      $error("FAIL %s done: observed=%b expected=%b", tag, done, ed);
    end
  endtask

  logic [N-1:0] ra, rb, rexp, held;
  logic         rinf;

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;

    // reset
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0);
    chk("reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // 1 + 2 = 3 with a single done pulse, then hold
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h4800_0000);
    chk("one_plus_two", 32'h4C00_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
    chk("hold_after_done", 32'h4C00_0000, 1'b0, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    chk("one_plus_one", 32'h4800_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'hC000_0000);
    chk("cancel", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'hC000_0000, 32'hB800_0000);
    chk("neg_one_neg_two", 32'hB400_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h8000_0000, 32'h4000_0000);
    chk("nar_operand", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678);
    chk("zero_operand", 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, MAXP, MAXP);
    chk("maxpos_sat", MAXP, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h0000_0001);
    chk("tiny_addend", 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, MINP, MINP);
    chk("minpos_twice", MINP, 1'b0, 1'b0, 1'b1);

    // reset wins over a simultaneous start
    cyc(1'b1, 1'b1, 32'h4000_0000, 32'h4800_0000);
    chk("rst_with_start", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // back-to-back starts
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h4800_0000);
    chk("b2b_first", 32'h4C00_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    chk("b2b_second", 32'h4800_0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0);
    chk("b2b_end", 32'h4800_0000, 1'b0, 1'b0, 1'b0);

    // random operands against the exact-value reference
    held = 32'h4800_0000;
    rinf = 1'b0;
    for (int t = 0; t < 300; t++) begin
      ra = rand_op();
      case ($urandom_range(0, 3))
        0:       rb = (~ra + 1'b1) + N'($urandom_range(0, 3));
        1:       rb = ra;
        default: rb = rand_op();
      endcase
      if ($urandom_range(0, 9) == 0) begin
        cyc(1'b0, 1'b0, ra, rb);
        chk("rand_idle", held, rinf, (held == '0), 1'b0);
      end else begin
        rexp = ref_add(ra, rb);
        rinf = (ra == NAR) || (rb == NAR);
        cyc(1'b0, 1'b1, ra, rb);
        chk($sformatf("rand %h+%h", ra, rb), rexp, rinf, (rexp == '0), 1'b1);
        held = rexp;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
